// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand resolution and hazard stalls.
// Macro ID_EX_FORWARD_EN enables EX/MEM/WB forwarding; when undefined, every RAW hazard interlocks.
module id_ex_stage #(
  parameter int XLEN     = 64,
  parameter int REG_AW   = 5,
  parameter int ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_AW-1:0]   id_rd,
  input  logic [XLEN-1:0]     id_rdata1,
  input  logic [XLEN-1:0]     id_rdata2,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  input  logic                id_mem_write,
  input  logic                id_alu_src,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [XLEN-1:0]     ex_result,
  input  logic [REG_AW-1:0]   mem_rd,
  input  logic                mem_reg_write,
  input  logic [XLEN-1:0]     mem_result,
  input  logic [REG_AW-1:0]   wb_rd,
  input  logic                wb_reg_write,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  input  logic                hold_in,
  output logic                stall_out,
  output logic                ex_valid,
  output logic [XLEN-1:0]     ex_op1,
  output logic [XLEN-1:0]     ex_op2,
  output logic [XLEN-1:0]     ex_imm,
  output logic [REG_AW-1:0]   ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  output logic                ex_mem_write,
  output logic                ex_alu_src,
  output logic [ALU_OP_W-1:0] ex_alu_op
);

  logic                ex_valid_q, ex_valid_d;
  logic [XLEN-1:0]     ex_op1_q, ex_op1_d;
  logic [XLEN-1:0]     ex_op2_q, ex_op2_d;
  logic [XLEN-1:0]     ex_imm_q, ex_imm_d;
  logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
  logic                ex_reg_write_q, ex_reg_write_d;
  logic                ex_mem_read_q, ex_mem_read_d;
  logic                ex_mem_write_q, ex_mem_write_d;
  logic                ex_alu_src_q, ex_alu_src_d;
  logic [ALU_OP_W-1:0] ex_alu_op_q, ex_alu_op_d;

  logic            hazard;
  logic [XLEN-1:0] op1_res, op2_res;

`ifdef ID_EX_FORWARD_EN
  // A load in EX has no data yet, so it is skipped and the lookup falls through to MEM/WB.
  function automatic logic [XLEN-1:0] resolve(input logic [REG_AW-1:0] s,
                                              input logic [XLEN-1:0]   rdata);
    if (s == '0)
      resolve = '0;
    else if (ex_valid_q && ex_reg_write_q && !ex_mem_read_q && ex_rd_q == s)
      resolve = ex_result;
    else if (mem_reg_write && mem_rd == s)
      resolve = mem_result;
    else if (wb_reg_write && wb_rd == s)
      resolve = wb_data;
    else
      resolve = rdata;
  endfunction

  logic ld_in_ex;
  assign ld_in_ex = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0);
  assign hazard   = ld_in_ex && id_valid &&
                    ((id_use_rs1 && id_rs1 == ex_rd_q) || (id_use_rs2 && id_rs2 == ex_rd_q));
`else
  function automatic logic [XLEN-1:0] resolve(input logic [REG_AW-1:0] s,
                                              input logic [XLEN-1:0]   rdata);
    resolve = (s == '0) ? '0 : rdata;
  endfunction

  // Any in-flight writer of a used source blocks issue until it has retired.
  function automatic logic busy(input logic [REG_AW-1:0] s);
    busy = (s != '0) &&
           ((ex_valid_q && ex_reg_write_q && ex_rd_q == s) ||
            (mem_reg_write && mem_rd == s) ||
            (wb_reg_write && wb_rd == s));
  endfunction

  assign hazard = id_valid && ((id_use_rs1 && busy(id_rs1)) || (id_use_rs2 && busy(id_rs2)));

  logic unused_fwd;
  assign unused_fwd = ^{ex_result, mem_result, wb_data};
`endif

  assign op1_res = resolve(id_rs1, id_rdata1);
  assign op2_res = resolve(id_rs2, id_rdata2);

  always_comb begin
    stall_out      = 1'b0;
    ex_valid_d     = ex_valid_q;
    ex_op1_d       = ex_op1_q;
    ex_op2_d       = ex_op2_q;
    ex_imm_d       = ex_imm_q;
    ex_rd_d        = ex_rd_q;
    ex_reg_write_d = ex_reg_write_q;
    ex_mem_read_d  = ex_mem_read_q;
    ex_mem_write_d = ex_mem_write_q;
    ex_alu_src_d   = ex_alu_src_q;
    ex_alu_op_d    = ex_alu_op_q;

    if (!rst && !flush)
      stall_out = hold_in || hazard;

    if (flush || (!hold_in && hazard)) begin
      ex_valid_d     = 1'b0;
      ex_op1_d       = '0;
      ex_op2_d       = '0;
      ex_imm_d       = '0;
      ex_rd_d        = '0;
      ex_reg_write_d = 1'b0;
      ex_mem_read_d  = 1'b0;
      ex_mem_write_d = 1'b0;
      ex_alu_src_d   = 1'b0;
      ex_alu_op_d    = '0;
    end else if (!hold_in) begin
      ex_valid_d     = id_valid;
      ex_op1_d       = op1_res;
      ex_op2_d       = op2_res;
      ex_imm_d       = id_imm;
      ex_rd_d        = id_rd;
      ex_reg_write_d = id_valid && id_reg_write;
      ex_mem_read_d  = id_valid && id_mem_read;
      ex_mem_write_d = id_valid && id_mem_write;
      ex_alu_src_d   = id_valid && id_alu_src;
      ex_alu_op_d    = id_valid ? id_alu_op : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q     <= 1'b0;
      ex_op1_q       <= '0;
      ex_op2_q       <= '0;
      ex_imm_q       <= '0;
      ex_rd_q        <= '0;
      ex_reg_write_q <= 1'b0;
      ex_mem_read_q  <= 1'b0;
      ex_mem_write_q <= 1'b0;
      ex_alu_src_q   <= 1'b0;
      ex_alu_op_q    <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_op1_q       <= ex_op1_d;
      ex_op2_q       <= ex_op2_d;
      ex_imm_q       <= ex_imm_d;
      ex_rd_q        <= ex_rd_d;
      ex_reg_write_q <= ex_reg_write_d;
      ex_mem_read_q  <= ex_mem_read_d;
      ex_mem_write_q <= ex_mem_write_d;
      ex_alu_src_q   <= ex_alu_src_d;
      ex_alu_op_q    <= ex_alu_op_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_op1       = ex_op1_q;
  assign ex_op2       = ex_op2_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rd        = ex_rd_q;
  assign ex_reg_write = ex_reg_write_q;
  assign ex_mem_read  = ex_mem_read_q;
  assign ex_mem_write = ex_mem_write_q;
  assign ex_alu_src   = ex_alu_src_q;
  assign ex_alu_op    = ex_alu_op_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed and random checks of id_ex_stage against a reference model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_use_rs1, id_use_rs2;
  logic [4:0]  id_rs1, id_rs2, id_rd, mem_rd, wb_rd;
  logic [63:0] id_rdata1, id_rdata2, id_imm, ex_result, mem_result, wb_data;
  logic        id_reg_write, id_mem_read, id_mem_write, id_alu_src;
  logic [3:0]  id_alu_op;
  logic        mem_reg_write, wb_reg_write, flush, hold_in;
  logic        stall_out, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src;
  logic [63:0] ex_op1, ex_op2, ex_imm;
  logic [4:0]  ex_rd;
  logic [3:0]  ex_alu_op;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .ex_result(ex_result),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .flush(flush), .hold_in(hold_in), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op)
  );

  typedef struct packed {
    logic        v;
    logic [63:0] op1, op2, imm;
    logic [4:0]  rd;
    logic        rw, mr, mw, as;
    logic [3:0]  op;
  } ex_t;

  ex_t m, m_next;
  logic exp_stall;
  int n_pass = 0;
  int n_total = 0;

  function automatic logic [63:0] m_operand(input logic [4:0] s, input logic [63:0] rdata);
`ifdef ID_EX_FORWARD_EN
    logic [4:0]  prd[3];
    logic        pwe[3];
    logic [63:0] pdat[3];
    prd  = '{m.rd, mem_rd, wb_rd};
    pwe  = '{m.v & m.rw & ~m.mr, mem_reg_write, wb_reg_write};
    pdat = '{ex_result, mem_result, wb_data};
`endif
    if (s == 5'd0) return 64'd0;
`ifdef ID_EX_FORWARD_EN
    for (int i = 0; i < 3; i++)
      if (pwe[i] && prd[i] == s) return pdat[i];
`endif
    return rdata;
  endfunction

  function automatic logic m_hazard();
    logic [4:0] used[$];
    if (!id_valid) return 1'b0;
    if (id_use_rs1) used.push_back(id_rs1);
    if (id_use_rs2) used.push_back(id_rs2);
    foreach (used[i]) begin
`ifdef ID_EX_FORWARD_EN
      if (m.v && m.mr && m.rd != 0 && used[i] == m.rd) return 1'b1;
`else
      if (used[i] != 0 && ((m.v && m.rw && m.rd == used[i]) ||
                           (mem_reg_write && mem_rd == used[i]) ||
                           (wb_reg_write && wb_rd == used[i]))) return 1'b1;
`endif
    end
    return 1'b0;
  endfunction

  function automatic ex_t m_step();
    ex_t n;
    n = '0;
    if (rst || flush) return n;
    if (hold_in) return m;
    if (m_hazard()) return n;
    n.v   = id_valid;
    n.op1 = m_operand(id_rs1, id_rdata1);
    n.op2 = m_operand(id_rs2, id_rdata2);
    n.imm = id_imm;
    n.rd  = id_rd;
    n.rw  = id_valid & id_reg_write;
    n.mr  = id_valid & id_mem_read;
    n.mw  = id_valid & id_mem_write;
    n.as  = id_valid & id_alu_src;
    n.op  = id_valid ? id_alu_op : 4'd0;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    m_next    = m_step();
    exp_stall = !rst && !flush && (hold_in || m_hazard());
    #1;
    chk("stall_out", {63'd0, stall_out}, {63'd0, exp_stall});
    @(posedge clk);
    m = m_next;
    #1;
    chk("ex_valid", {63'd0, ex_valid}, {63'd0, m.v});
    chk("ex_op1", ex_op1, m.op1);
    chk("ex_op2", ex_op2, m.op2);
    chk("ex_imm", ex_imm, m.imm);
    chk("ex_rd", {59'd0, ex_rd}, {59'd0, m.rd});
    chk("ex_ctrl", {60'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src},
        {60'd0, m.rw, m.mr, m.mw, m.as});
    chk("ex_alu_op", {60'd0, ex_alu_op}, {60'd0, m.op});
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic [63:0] d1, input logic [63:0] d2,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_rdata1 = d1; id_rdata2 = d2; id_imm = {$urandom, $urandom};
    id_reg_write = rw; id_mem_read = mr; id_mem_write = 1'b0;
    id_alu_src = 1'($urandom); id_alu_op = 4'($urandom);
  endtask

  task automatic set_prod(input logic [63:0] exr, input logic [4:0] mrd, input logic mwe,
                          input logic [63:0] mres, input logic [4:0] wrd, input logic wwe,
                          input logic [63:0] wdat);
    ex_result = exr; mem_rd = mrd; mem_reg_write = mwe; mem_result = mres;
    wb_rd = wrd; wb_reg_write = wwe; wb_data = wdat;
  endtask

  initial begin
    m = '0;
    rst = 1'b1; flush = 1'b0; hold_in = 1'b0;
    set_id(1, 1, 2, 1, 1, 3, 64'h11, 64'h22, 1, 0);
    set_prod(64'h0, 0, 0, 64'h0, 0, 0, 64'h0);
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    // Dependent on the add in EX
    set_id(1, 1, 2, 1, 1, 5, 64'h1, 64'h2, 1, 0);
    step();
    set_id(1, 5, 2, 1, 1, 6, 64'hDEAD, 64'h2, 1, 0);
    set_prod(64'hA5, 0, 0, 64'h0, 0, 0, 64'h0);
    step();
    // EX/MEM/WB all target x7
    set_id(1, 1, 2, 1, 1, 7, 64'h1, 64'h2, 1, 0);
    set_prod(64'h0, 0, 0, 64'h0, 0, 0, 64'h0);
    step();
    set_id(1, 1, 7, 1, 1, 7, 64'h1, 64'hBAD, 0, 0);
    set_prod(64'h1, 7, 1, 64'h2, 7, 1, 64'h3);
    step();
    set_id(1, 1, 7, 1, 1, 8, 64'h1, 64'hBAD, 1, 0);
    step();
    // Load-use on x9
    set_prod(64'h0, 0, 0, 64'h0, 0, 0, 64'h0);
    set_id(1, 1, 2, 1, 1, 9, 64'h1, 64'h2, 1, 1);
    step();
    set_id(1, 3, 9, 1, 1, 10, 64'h3, 64'hBAD, 1, 0);
    step();
    set_prod(64'h0, 9, 1, 64'h77, 0, 0, 64'h0);
    step();
    // x0 never forwarded
    set_id(1, 1, 2, 1, 1, 0, 64'h1, 64'h2, 1, 0);
    set_prod(64'h0, 0, 0, 64'h0, 0, 0, 64'h0);
    step();
    set_id(1, 0, 0, 1, 1, 4, 64'h0, 64'h0, 1, 0);
    set_prod(64'h55, 0, 1, 64'h66, 0, 1, 64'h77);
    step();
    // Flush beats load-use, then hold
    set_prod(64'h0, 0, 0, 64'h0, 0, 0, 64'h0);
    set_id(1, 1, 2, 1, 1, 9, 64'h1, 64'h2, 1, 1);
    step();
    set_id(1, 9, 2, 1, 1, 11, 64'h9, 64'h2, 1, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    set_id(1, 12, 13, 1, 1, 14, 64'h12, 64'h13, 1, 0);
    step();
    hold_in = 1'b1;
    set_id(1, 15, 16, 1, 1, 17, 64'h15, 64'h16, 1, 0);
    for (int i = 0; i < 3; i++) step();
    hold_in = 1'b0;
    step();
    // Random traffic; ID stays put while a stall is expected
    for (int i = 0; i < 500; i++) begin
      if (!exp_stall || rst || flush)
        set_id(1'($urandom_range(0, 7) != 0), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               5'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom},
               1'($urandom), 1'($urandom_range(0, 3) == 0));
      set_prod({$urandom, $urandom}, 5'($urandom_range(0, 7)), 1'($urandom),
               {$urandom, $urandom}, 5'($urandom_range(0, 7)), 1'($urandom),
               {$urandom, $urandom});
      rst     = ($urandom_range(0, 49) == 0);
      flush   = ($urandom_range(0, 9) == 0);
      hold_in = ($urandom_range(0, 9) == 0);
      step();
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
